// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 sequencer and the datapath mux decoders.
package lc3_pkg;

    typedef enum logic [4:0] {
        HALTED  = 5'd0,
        S18     = 5'd1,
        S33_1   = 5'd2,
        S33_2   = 5'd3,
        S35     = 5'd4,
        S32     = 5'd5,
        S01     = 5'd6,
        S05     = 5'd7,
        S09     = 5'd8,
        S06     = 5'd9,
        S25_1   = 5'd10,
        S25_2   = 5'd11,
        S27     = 5'd12,
        S07     = 5'd13,
        S23     = 5'd14,
        S16_1   = 5'd15,
        S16_2   = 5'd16,
        S00     = 5'd17,
        S22     = 5'd18,
        S12     = 5'd19,
        S04     = 5'd20,
        S21     = 5'd21,
        PAUSE_1 = 5'd22,
        PAUSE_2 = 5'd23
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

endpackage

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencing/decode unit: Moore FSM driving all datapath
// load enables, bus gates, mux selects and memory strobes.
module lc3_isdu
    import lc3_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    input  logic       Mem_R,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_WE,
    output logic       Mem_OE,
    output logic [4:0] State_dbg
);

    state_t state, state_n;
    // IR bits are stable from S35 onward; registering them keeps every
    // output a pure function of flops.
    logic   ir5_q, ir11_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= HALTED;
            ir5_q  <= 1'b0;
            ir11_q <= 1'b0;
        end else begin
            state  <= state_n;
            ir5_q  <= IR_5;
            ir11_q <= IR_11;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            HALTED:  if (Run) state_n = S18;
            S18:     state_n = S33_1;
            S33_1:   state_n = S33_2;
            S33_2:   if (Mem_R) state_n = S35;
            S35:     state_n = S32;
            S32: begin
                case (Opcode)
                    OP_ADD:  state_n = S01;
                    OP_AND:  state_n = S05;
                    OP_NOT:  state_n = S09;
                    OP_LDR:  state_n = S06;
                    OP_STR:  state_n = S07;
                    OP_BR:   state_n = S00;
                    OP_JMP:  state_n = S12;
                    OP_JSR:  state_n = S04;
                    OP_PSE:  state_n = PAUSE_1;
                    default: state_n = S18;
                endcase
            end
            S06:     state_n = S25_1;
            S25_1:   state_n = S25_2;
            S25_2:   if (Mem_R) state_n = S27;
            S07:     state_n = S23;
            S23:     state_n = S16_1;
            S16_1:   state_n = S16_2;
            S16_2:   if (Mem_R) state_n = S18;
            S00:     state_n = BEN ? S22 : S18;
            S04:     state_n = S21;
            PAUSE_1: if (Continue) state_n = PAUSE_2;
            PAUSE_2: if (!Continue) state_n = S18;
            default: state_n = S18;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_CE     = 1'b0;
        Mem_WE     = 1'b0;
        Mem_OE     = 1'b0;
        case (state)
            S18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = PCMUX_INC;
            end
            S33_1, S25_1: begin
                Mem_CE = 1'b1;
                Mem_OE = 1'b1;
            end
            S33_2, S25_2: begin
                Mem_CE = 1'b1;
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S32: LD_BEN = 1'b1;
            S01, S05, S09: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR1MUX  = 1'b0;
                SR2MUX  = (state == S09) ? 1'b0 : ir5_q;
                ALUK    = (state == S01) ? ALUK_ADD :
                          (state == S05) ? ALUK_AND : ALUK_NOT;
            end
            S06, S07: begin
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S23: begin
                SR1MUX  = 1'b1;
                ALUK    = ALUK_PASS;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S16_1, S16_2: begin
                Mem_CE = 1'b1;
                Mem_WE = 1'b1;
            end
            S22: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_OFF9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S12: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S04: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S21: begin
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
                ADDR1MUX = ~ir11_q;
                ADDR2MUX = ir11_q ? ADDR2_OFF11 : ADDR2_ZERO;
            end
            default: ;
        endcase
    end

    assign State_dbg = state;

endmodule

// File: tb/tb_lc3_isdu.sv
// Directed bench: builds the expected per-cycle state/output trace of each
// instruction, replays its inputs and compares the DUT every cycle.
module tb_lc3_isdu;
    import lc3_pkg::*;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       ce, we, oe;
    } outs_t;

    typedef struct {
        state_t     st;
        outs_t      o;
        logic       rst, run, cont, memr;
        logic [3:0] opc;
        logic       ir5, ir11, ben;
    } entry_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0, Run = 1'b0, Continue = 1'b0;
    logic [3:0] Opcode = 4'd0;
    logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0, Mem_R = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic       Mem_CE, Mem_WE, Mem_OE;
    logic [4:0] State_dbg;

    lc3_isdu dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_R(Mem_R),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_CE(Mem_CE), .Mem_WE(Mem_WE),
        .Mem_OE(Mem_OE), .State_dbg(State_dbg)
    );

    always #5 Clk = ~Clk;

    outs_t dut_o;
    assign dut_o = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                    GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                    DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                    Mem_CE, Mem_WE, Mem_OE};

    int         n_total = 0, n_pass = 0, cyc = 0;
    int         mdr_cnt = 0, p1_cnt = 0;
    entry_t     plan[$];
    entry_t     cur;
    logic       cur_vld = 1'b0;
    logic [3:0] p_opc = 4'd0;
    logic       p_ir5 = 1'b0, p_ir11 = 1'b0, p_ben = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    task automatic push(input state_t s, input outs_t o, input logic memr,
                        input logic cont, input logic rst, input logic run);
        entry_t e;
        e.st = s; e.o = o; e.memr = memr; e.cont = cont; e.rst = rst; e.run = run;
        e.opc = p_opc; e.ir5 = p_ir5; e.ir11 = p_ir11; e.ben = p_ben;
        plan.push_back(e);
    endtask

    // Fetch through decode; w = cycles Mem_R stays low in S33_2.
    task automatic plan_fetch(input int w);
        outs_t o;
        o = '0; o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; o.pcmux = PCMUX_INC;
        push(S18, o, 1, 0, 1, 0);
        o = '0; o.ce = 1; o.oe = 1;
        push(S33_1, o, 1, 0, 1, 0);
        o.ld_mdr = 1;
        for (int i = 0; i <= w; i++) push(S33_2, o, (i == w), 0, 1, 0);
        o = '0; o.gate_mdr = 1; o.ld_ir = 1;
        push(S35, o, 1, 0, 1, 0);
        o = '0; o.ld_ben = 1;
        push(S32, o, 1, 0, 1, 0);
    endtask

    task automatic plan_instr(input logic [3:0] opc, input logic ir5, input logic ir11,
                              input logic ben, input int wf, input int wm);
        outs_t o;
        p_opc = opc; p_ir5 = ir5; p_ir11 = ir11; p_ben = ben;
        plan_fetch(wf);
        o = '0;
        case (opc)
            OP_ADD, OP_AND, OP_NOT: begin
                o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1;
                o.sr2mux = (opc == OP_NOT) ? 1'b0 : ir5;
                o.aluk = (opc == OP_ADD) ? ALUK_ADD : (opc == OP_AND) ? ALUK_AND : ALUK_NOT;
                push(opc == OP_ADD ? S01 : opc == OP_AND ? S05 : S09, o, 1, 0, 1, 0);
            end
            OP_LDR, OP_STR: begin
                o.addr1mux = 1; o.addr2mux = ADDR2_OFF6; o.gate_marmux = 1; o.ld_mar = 1;
                if (opc == OP_LDR) begin
                    push(S06, o, 1, 0, 1, 0);
                    o = '0; o.ce = 1; o.oe = 1;
                    push(S25_1, o, 1, 0, 1, 0);
                    o.ld_mdr = 1;
                    for (int i = 0; i <= wm; i++) push(S25_2, o, (i == wm), 0, 1, 0);
                    o = '0; o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1;
                    push(S27, o, 1, 0, 1, 0);
                end else begin
                    push(S07, o, 1, 0, 1, 0);
                    o = '0; o.sr1mux = 1; o.aluk = ALUK_PASS; o.gate_alu = 1; o.ld_mdr = 1;
                    push(S23, o, 1, 0, 1, 0);
                    o = '0; o.ce = 1; o.we = 1;
                    push(S16_1, o, 1, 0, 1, 0);
                    for (int i = 0; i <= wm; i++) push(S16_2, o, (i == wm), 0, 1, 0);
                end
            end
            OP_BR: begin
                push(S00, o, 1, 0, 1, 0);
                if (ben) begin
                    o.addr2mux = ADDR2_OFF9; o.pcmux = PCMUX_ADDER; o.ld_pc = 1;
                    push(S22, o, 1, 0, 1, 0);
                end
            end
            OP_JMP: begin
                o.addr1mux = 1; o.addr2mux = ADDR2_ZERO; o.pcmux = PCMUX_ADDER; o.ld_pc = 1;
                push(S12, o, 1, 0, 1, 0);
            end
            OP_JSR: begin
                o.gate_pc = 1; o.drmux = 1; o.ld_reg = 1;
                push(S04, o, 1, 0, 1, 0);
                o = '0; o.pcmux = PCMUX_ADDER; o.ld_pc = 1;
                if (ir11) o.addr2mux = ADDR2_OFF11;
                else      o.addr1mux = 1;
                push(S21, o, 1, 0, 1, 0);
            end
            default: ;
        endcase
    endtask

    // Pause: n_lo cycles with Continue low, release, then n_hi cycles held high.
    task automatic plan_pause(input int n_lo, input int n_hi);
        p_opc = OP_PSE; p_ir5 = 0; p_ir11 = 0; p_ben = 0;
        plan_fetch(0);
        for (int i = 0; i < n_lo; i++) push(PAUSE_1, '0, 1, 0, 1, 0);
        push(PAUSE_1, '0, 1, 1, 1, 0);
        for (int i = 0; i < n_hi; i++) push(PAUSE_2, '0, 1, 1, 1, 0);
        push(PAUSE_2, '0, 1, 0, 1, 0);
    endtask

    // Reset lands while the fetch read is still waiting, then restart.
    task automatic plan_abort();
        outs_t o;
        p_opc = OP_ADD;
        o = '0; o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1;
        push(S18, o, 1, 0, 1, 0);
        o = '0; o.ce = 1; o.oe = 1;
        push(S33_1, o, 0, 0, 1, 0);
        o.ld_mdr = 1;
        push(S33_2, o, 0, 0, 0, 0);
        push(HALTED, '0, 1, 0, 1, 0);
        push(HALTED, '0, 1, 0, 1, 1);
    endtask

    always @(negedge Clk) begin
        if (cur_vld) begin
            chk("state", 32'(State_dbg), 32'(cur.st));
            chk("outputs", 32'(dut_o), 32'(cur.o));
            if (State_dbg == S25_2 && LD_MDR) mdr_cnt++;
            if (State_dbg == PAUSE_1) p1_cnt++;
        end
    end

    initial begin
        int n0;
        push(HALTED, '0, 0, 0, 0, 0);
        push(HALTED, '0, 0, 0, 1, 0);
        push(HALTED, '0, 0, 0, 1, 1);
        n0 = plan.size();
        plan_instr(OP_ADD, 1, 0, 0, 0, 0);
        chk("add_len", 32'(plan.size() - n0), 32'd6);
        plan_instr(OP_AND, 0, 0, 0, 0, 0);
        plan_instr(OP_NOT, 0, 0, 0, 0, 0);
        plan_instr(OP_LDR, 0, 0, 0, 0, 3);
        n0 = plan.size();
        plan_instr(OP_LDR, 1, 1, 0, 0, 0);
        chk("ldr_len", 32'(plan.size() - n0), 32'd9);
        n0 = plan.size();
        plan_instr(OP_STR, 0, 0, 0, 0, 0);
        chk("str_len", 32'(plan.size() - n0), 32'd9);
        plan_instr(OP_STR, 1, 0, 1, 1, 2);
        plan_instr(OP_BR, 0, 0, 0, 0, 0);
        plan_instr(OP_BR, 0, 0, 1, 0, 0);
        plan_instr(OP_JMP, 0, 0, 0, 0, 0);
        plan_instr(OP_JSR, 0, 1, 0, 0, 0);
        plan_instr(OP_JSR, 1, 0, 0, 0, 0);
        plan_instr(4'b1000, 0, 0, 0, 0, 0);
        plan_pause(5, 2);
        plan_abort();
        plan_instr(OP_ADD, 0, 0, 0, 0, 0);

        @(posedge Clk); #1;
        while (plan.size() > 0) begin
            cur = plan.pop_front();
            Reset = cur.rst; Run = cur.run; Continue = cur.cont; Mem_R = cur.memr;
            Opcode = cur.opc; IR_5 = cur.ir5; IR_11 = cur.ir11; BEN = cur.ben;
            cur_vld = 1'b1;
            @(posedge Clk); #1;
            cyc++;
        end
        cur_vld = 1'b0;
        chk("ldr_mdr_hold", 32'(mdr_cnt), 32'd5);
        chk("pause1_cycles", 32'(p1_cnt), 32'd6);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
